// File: rtl/fir_pkg.sv
// Shared definitions for the multi-cycle FIR frame sequencer: default sizes,
// FSM encoding and helpers for the frame length and cfg_addr field split.
package fir_pkg;

  localparam int DW_DEF   = 16;
  localparam int NSEC_DEF = 4;
  localparam int LGC_DEF  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Frame length in clocks for a given log2 cycle count.
  function automatic int cycles_of(input int lgc);
    return 1 << lgc;
  endfunction

  // Width of the section field in cfg_addr = {section, tap}.
  function automatic int sec_bits(input int nsec);
    return $clog2(nsec);
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient store: one write port, NSEC parallel read lanes sharing one
// address, synchronous read with write-first behaviour on an address collision.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NSEC = NSEC_DEF,
  parameter int LGC  = LGC_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(NSEC)-1:0]  wsec,
  input  logic [LGC-1:0]           wtap,
  input  logic [DW-1:0]            wdata,
  input  logic [LGC-1:0]           raddr,
  output logic [NSEC*DW-1:0]       rdata
);

  localparam int CYCLES = cycles_of(LGC);
  localparam int SW     = sec_bits(NSEC);

  for (genvar k = 0; k < NSEC; k++) begin : g_lane
    logic [DW-1:0] mem [CYCLES];
    logic [DW-1:0] rd_q;
    logic          lane_we;

    assign lane_we = we && (wsec == SW'(k));

    // Write-first so a write landing on the clock of the first tap read is seen.
    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem[wtap] <= wdata;
      end
      if (lane_we && (wtap == raddr)) begin
        rd_q <= wdata;
      end else begin
        rd_q <= mem[raddr];
      end
    end

    assign rdata[k*DW +: DW] = rd_q;
  end

endmodule

// File: rtl/fir_mc_sequencer.sv
// Frame sequencer for chained multi-cycle FIR sections: runs CYCLES ticks per
// accepted sample and serves coefficients, deferring host writes to frame gaps.
module fir_mc_sequencer
  import fir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NSEC = NSEC_DEF,
  parameter int LGC  = LGC_DEF
) (
  input  logic                         clk_sample,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DW-1:0]                s_data,
  output logic [DW-1:0]                chain_in,
  output logic                         ce,
  output logic [15:0]                  cycle,
  output logic [15:0]                  total_cycles,
  output logic [NSEC*DW-1:0]           coeff,
  output logic                         m_valid,
  output logic [15:0]                  frame_cnt,
  input  logic                         cfg_we,
  input  logic [LGC+$clog2(NSEC)-1:0]  cfg_addr,
  input  logic [DW-1:0]                cfg_data,
  output logic                         cfg_busy,
  output logic                         dbg_state
);

  localparam int CYCLES = cycles_of(LGC);
  localparam int SW     = sec_bits(NSEC);

  // Handshake: a sample transfers on a clock where s_valid & s_ready are both
  // high; s_ready opens only in IDLE or at the last frame cycle, never while a
  // host write is pending, and s_valid may be held across frames.

  state_t              state, state_nx;
  logic [LGC-1:0]      cyc;
  logic                primed;
  logic                last, accept;
  logic                wr_direct, capture, commit;
  logic [LGC+SW-1:0]   pend_addr;
  logic [DW-1:0]       pend_data;
  logic [LGC+SW-1:0]   bank_addr;
  logic [DW-1:0]       bank_data;
  logic [LGC-1:0]      rd_addr;

  assign last      = (state == ST_RUN) && (cyc == LGC'(CYCLES - 1));
  assign accept    = s_valid && s_ready;
  assign wr_direct = cfg_we && !cfg_busy && (state == ST_IDLE);
  assign capture   = cfg_we && !cfg_busy && (state == ST_RUN);
  assign commit    = cfg_busy && ((state == ST_IDLE) || last);

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (last && !accept) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ce      = 1'b0;
    s_ready = 1'b0;
    case (state)
      ST_IDLE: s_ready = reset_n && enable && !cfg_busy;
      ST_RUN: begin
        ce      = 1'b1;
        s_ready = reset_n && enable && !cfg_busy && last;
      end
      default: ;
    endcase
  end

  // Datapath: cycle counter wraps naturally at the last frame cycle.
  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      cyc       <= '0;
      chain_in  <= '0;
      frame_cnt <= '0;
      m_valid   <= 1'b0;
      primed    <= 1'b0;
      cfg_busy  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      if (accept) begin
        chain_in  <= s_data;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (accept || (state == ST_IDLE)) begin
        cyc <= '0;
      end else begin
        cyc <= cyc + LGC'(1);
      end
      m_valid <= (state == ST_RUN) && (cyc == LGC'(2)) && primed;
      if (last) begin
        primed <= 1'b1;
      end
      if (capture) begin
        cfg_busy  <= 1'b1;
        pend_addr <= cfg_addr;
        pend_data <= cfg_data;
      end else if (commit) begin
        cfg_busy <= 1'b0;
      end
    end
  end

  // Read address leads the cycle index by one so coeff lines up with cycle.
  assign rd_addr   = (state == ST_RUN) ? (cyc + LGC'(1)) : '0;
  assign bank_addr = commit ? pend_addr : cfg_addr;
  assign bank_data = commit ? pend_data : cfg_data;

  fir_coeff_bank #(
    .DW   (DW),
    .NSEC (NSEC),
    .LGC  (LGC)
  ) u_bank (
    .clk   (clk_sample),
    .we    (wr_direct || commit),
    .wsec  (bank_addr[LGC +: SW]),
    .wtap  (bank_addr[LGC-1:0]),
    .wdata (bank_data),
    .raddr (rd_addr),
    .rdata (coeff)
  );

  assign cycle        = 16'(cyc);
  assign total_cycles = 16'(CYCLES - 1);
  assign dbg_state    = state;

endmodule

// File: tb/tb_fir_mc_sequencer.sv
// Directed bench for fir_mc_sequencer (DW=16, NSEC=4, LGC=3).
module tb_fir_mc_sequencer;

  logic        clk_sample = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [15:0] chain_in;
  logic        ce;
  logic [15:0] cycle;
  logic [15:0] total_cycles;
  logic [63:0] coeff;
  logic        m_valid;
  logic [15:0] frame_cnt;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_busy;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  always #5 clk_sample = ~clk_sample;

  fir_mc_sequencer #(.DW(16), .NSEC(4), .LGC(3)) dut (
    .clk_sample   (clk_sample),
    .reset_n      (reset_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .chain_in     (chain_in),
    .ce           (ce),
    .cycle        (cycle),
    .total_cycles (total_cycles),
    .coeff        (coeff),
    .m_valid      (m_valid),
    .frame_cnt    (frame_cnt),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_busy     (cfg_busy),
    .dbg_state    (dbg_state)
  );

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk_sample);
    #1;
    chk("rst_ce", ce, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_chain_in", chain_in, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_state", dbg_state, 0);
    chk("total_cycles", total_cycles, 7);
    reset_n = 1'b1;

    // 1: single sample
    enable = 1'b1; s_valid = 1'b1; s_data = 16'd100;
    #1;
    chk("t1_s_ready_idle", s_ready, 1);
    tick(); s_valid = 1'b0; exp_fc++;
    chk("t1_chain_in", chain_in, 100);
    chk("t1_frame_cnt", frame_cnt, exp_fc);
    chk("t1_s_ready_run", s_ready, 0);
    for (int c = 0; c < 8; c++) begin
      chk("t1_cycle", cycle, c);
      chk("t1_ce", ce, 1);
      chk("t1_m_valid", m_valid, 0);
      chk("t1_s_ready", s_ready, (c == 7) ? 1 : 0);
      tick();
    end
    chk("t1_idle_ce", ce, 0);
    chk("t1_idle_cycle", cycle, 0);
    chk("t1_idle_m_valid", m_valid, 0);
    chk("t1_idle_frame_cnt", frame_cnt, 1);

    // 2: back-to-back from a fresh reset
    reset_n = 1'b0; #2; reset_n = 1'b1; exp_fc = 0;
    s_valid = 1'b1; s_data = 16'd1;
    tick();
    for (int i = 0; i < 24; i++) begin
      chk("t2_cycle", cycle, i % 8);
      chk("t2_ce", ce, 1);
      chk("t2_s_ready", s_ready, ((i % 8) == 7) ? 1 : 0);
      chk("t2_m_valid", m_valid, (((i % 8) == 3) && (i >= 8)) ? 1 : 0);
      chk("t2_chain_in", chain_in, i / 8 + 1);
      chk("t2_frame_cnt", frame_cnt, i / 8 + 1);
      if (i == 0) s_data = 16'd2;
      if (i == 8) s_data = 16'd3;
      if (i == 16) s_valid = 1'b0;
      tick();
    end
    exp_fc = 3;
    chk("t2_idle_ce", ce, 0);
    chk("t2_idle_frame_cnt", frame_cnt, exp_fc);

    // 3: section 1 coefficients, then a write coinciding with an accept
    for (int t = 0; t < 8; t++) begin
      cfg_we = 1'b1; cfg_addr = {2'd1, 3'(t)}; cfg_data = 16'(t + 1);
      tick();
      chk("t3_busy_idle_write", cfg_busy, 0);
    end
    cfg_we = 1'b0;
    s_valid = 1'b1;
    tick(); s_valid = 1'b0; exp_fc++;
    for (int c = 0; c < 8; c++) begin
      chk("t3_cycle", cycle, c);
      chk("t3_coeff1", coeff[31:16], c + 1);
      tick();
    end
    cfg_we = 1'b1; cfg_addr = {2'd1, 3'd0}; cfg_data = 16'd42; s_valid = 1'b1;
    tick(); cfg_we = 1'b0; s_valid = 1'b0; exp_fc++;
    chk("t3_same_clk_cycle", cycle, 0);
    chk("t3_same_clk_coeff", coeff[31:16], 42);
    tick();
    chk("t3_tap1_coeff", coeff[31:16], 2);
    repeat (7) tick();
    chk("t3_idle_ce", ce, 0);
    chk("t3_frame_cnt", frame_cnt, exp_fc);

    // 4: write during RUN goes pending, second write dropped
    s_valid = 1'b1;
    tick(); s_valid = 1'b0; exp_fc++;
    repeat (3) tick();
    chk("t4_cycle3", cycle, 3);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'hfffb;
    tick();
    chk("t4_busy_set", cfg_busy, 1);
    cfg_data = 16'h0009;
    tick(); cfg_we = 1'b0;
    chk("t4_busy_hold", cfg_busy, 1);
    s_valid = 1'b1;
    tick(); tick();
    chk("t4_wrap_cycle", cycle, 7);
    chk("t4_wrap_s_ready", s_ready, 0);
    tick();
    chk("t4_after_wrap_ce", ce, 0);
    chk("t4_after_wrap_busy", cfg_busy, 0);
    chk("t4_after_wrap_fc", frame_cnt, exp_fc);
    chk("t4_idle_s_ready", s_ready, 1);
    tick(); s_valid = 1'b0; exp_fc++;
    chk("t4_coeff0", coeff[15:0], 16'hfffb);
    chk("t4_cycle0", cycle, 0);
    chk("t4_frame_cnt", frame_cnt, exp_fc);
    repeat (8) tick();

    // 5: enable dropped mid-frame
    s_valid = 1'b1;
    tick(); exp_fc++;
    repeat (4) tick();
    chk("t5_cycle4", cycle, 4);
    enable = 1'b0;
    repeat (3) tick();
    chk("t5_cycle7", cycle, 7);
    chk("t5_s_ready7", s_ready, 0);
    chk("t5_ce7", ce, 1);
    tick();
    chk("t5_idle_ce", ce, 0);
    chk("t5_idle_cycle", cycle, 0);
    chk("t5_idle_s_ready", s_ready, 0);
    chk("t5_frame_cnt", frame_cnt, exp_fc);
    tick();
    chk("t5_stay_idle", dbg_state, 0);
    s_valid = 1'b0;

    // 6: reset with a write pending
    enable = 1'b1; s_valid = 1'b1;
    tick(); s_valid = 1'b0;
    repeat (3) tick();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'd77;
    tick(); cfg_we = 1'b0;
    chk("t6_busy", cfg_busy, 1);
    tick();
    chk("t6_cycle5", cycle, 5);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ce", ce, 0);
    chk("t6_rst_cycle", cycle, 0);
    chk("t6_rst_s_ready", s_ready, 0);
    chk("t6_rst_chain_in", chain_in, 0);
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_frame_cnt", frame_cnt, 0);
    chk("t6_rst_busy", cfg_busy, 0);
    chk("t6_rst_state", dbg_state, 0);
    reset_n = 1'b1; s_valid = 1'b1;
    #1;
    chk("t6_s_ready", s_ready, 1);
    tick(); s_valid = 1'b0;
    chk("t6_coeff0_kept", coeff[15:0], 16'hfffb);
    chk("t6_frame_cnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
